// File: rtl/nios_pio_pkg.sv
// Shared constants for the extended PIO: Avalon register map and edge-capture modes.
package nios_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA      = 3'd0,
    ADDR_DIRECTION = 3'd1,
    ADDR_IRQMASK   = 3'd2,
    ADDR_EDGECAP   = 3'd3,
    ADDR_OUTSET    = 3'd4,
    ADDR_OUTCLR    = 3'd5
  } pio_addr_e;

  typedef enum int unsigned {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } pio_edge_e;

endpackage

// File: rtl/nios_pio_sync.sv
// Two-flop input synchroniser plus a history flop; emits per-bit edge events
// of the configured polarity one cycle ahead of their capture.
module nios_pio_sync
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s2,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= in_port;
      s2   <= s1;
      prev <= s2;
    end
  end

  generate
    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
      assign edge_det = ~s2 & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_det = s2 ^ prev;
    end else begin : g_rise
      assign edge_det = s2 & ~prev;
    end
  endgenerate

endmodule

// File: rtl/nios_pio_ext.sv
// Avalon-MM PIO with direction, irq mask, edge capture and atomic set/clear ports.
module nios_pio_ext
  import nios_pio_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd_w;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = &{1'b0, writedata};

  nios_pio_sync #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .s2       (s2),
    .edge_det (edge_det)
  );

  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  // Capture is OR'd in after the clear so a same-cycle edge survives a W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE;
      direction <= '0;
      irqmask   <= '0;
      edgecap   <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clr) | edge_det;
      if (wr) begin
        case (address)
          ADDR_DATA:      data_out  <= wdata;
          ADDR_DIRECTION: direction <= wdata;
          ADDR_IRQMASK:   irqmask   <= wdata;
          ADDR_OUTSET:    data_out  <= data_out | wdata;
          ADDR_OUTCLR:    data_out  <= data_out & ~wdata;
          default:        ;
        endcase
      end
    end
  end

  always_comb begin
    rd_w = '0;
    case (address)
      ADDR_DATA:      rd_w = s2;
      ADDR_DIRECTION: rd_w = direction;
      ADDR_IRQMASK:   rd_w = irqmask;
      ADDR_EDGECAP:   rd_w = edgecap;
      default:        rd_w = '0;
    endcase
    readdata              = '0;
    readdata[WIDTH-1:0]   = rd_w;
  end

  assign irq      = |(edgecap & irqmask);
  assign out_port = data_out;
  assign out_en   = direction;

endmodule

// File: tb/tb_nios_pio_ext.sv
// Bench for nios_pio_ext: three instances (rising/falling/any) on a shared bus,
// directed scenario tasks plus a random run against a register-map model.
module tb_nios_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_p  [3];
  logic [31:0] rd    [3];
  logic [7:0]  op    [3];
  logic [7:0]  oe    [3];
  logic        irq_v [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nios_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_p[0]), .out_port(op[0]), .out_en(oe[0]), .irq(irq_v[0]));

  nios_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_p[1]), .out_port(op[1]), .out_en(oe[1]), .irq(irq_v[1]));

  nios_pio_ext #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_p[2]), .out_port(op[2]), .out_en(oe[2]), .irq(irq_v[2]));

  // Reference model: register map plus an input history (newest first).
  logic [7:0] m_dout [3];
  logic [7:0] m_dir  [3];
  logic [7:0] m_mask [3];
  logic [7:0] m_cap  [3];
  logic [7:0] m_hist [3][3];

  function automatic logic [7:0] ev_of(input int k);
    logic [7:0] now_v, before_v, rose, fell;
    now_v    = m_hist[k][1];
    before_v = m_hist[k][2];
    rose = now_v & ~before_v;
    fell = before_v & ~now_v;
    if (k == 0) return rose;
    if (k == 1) return fell;
    return rose | fell;
  endfunction

  function automatic logic [31:0] mread(input int k, input logic [2:0] a);
    case (a)
      3'd0: return {24'd0, m_hist[k][1]};
      3'd1: return {24'd0, m_dir[k]};
      3'd2: return {24'd0, m_mask[k]};
      3'd3: return {24'd0, m_cap[k]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        m_dout[k] <= 8'hA5;
        m_dir[k]  <= 8'h00;
        m_mask[k] <= 8'h00;
        m_cap[k]  <= 8'h00;
        for (int j = 0; j < 3; j++) m_hist[k][j] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_cap[k] <= (m_cap[k] & ~((chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'h00))
                    | ev_of(k);
        if (chipselect && !write_n) begin
          case (address)
            3'd0: m_dout[k] <= writedata[7:0];
            3'd1: m_dir[k]  <= writedata[7:0];
            3'd2: m_mask[k] <= writedata[7:0];
            3'd4: m_dout[k] <= m_dout[k] | writedata[7:0];
            3'd5: m_dout[k] <= m_dout[k] & ~writedata[7:0];
            default: ;
          endcase
        end
        m_hist[k][0] <= in_p[k];
        m_hist[k][1] <= m_hist[k][0];
        m_hist[k][2] <= m_hist[k][1];
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) in_p[k] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (op[k] !== 8'hA5) begin nerr++; $display("FAIL reset_out_port k=%0d got %h expected a5", k, op[k]); end
      nvec++;
      if (oe[k] !== 8'h00) begin nerr++; $display("FAIL reset_out_en k=%0d got %h expected 00", k, oe[k]); end
      nvec++;
      if (irq_v[k] !== 1'b0) begin nerr++; $display("FAIL reset_irq k=%0d got %b expected 0", k, irq_v[k]); end
    end
    for (int a = 1; a <= 3; a++) begin
      address = 3'(a);
      #1;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (rd[k] !== 32'd0) begin nerr++; $display("FAIL reset_read a=%0d k=%0d got %h expected 0", a, k, rd[k]); end
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_set_clear();
    logic [7:0] exp_v [3];
    logic [31:0] dat [3];
    logic [2:0]  adr [3];
    exp_v[0] = 8'h0F; exp_v[1] = 8'hFF; exp_v[2] = 8'h7E;
    dat[0] = 32'h0F; dat[1] = 32'hF0; dat[2] = 32'h81;
    adr[0] = 3'd0; adr[1] = 3'd4; adr[2] = 3'd5;
    for (int s = 0; s < 3; s++) begin
      bus_write(adr[s], dat[s]);
      #1;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (op[k] !== exp_v[s]) begin nerr++; $display("FAIL set_clear step=%0d k=%0d got %h expected %h", s, k, op[k], exp_v[s]); end
      end
    end
    address = 3'd4;
    #1;
    nvec++;
    if (rd[0] !== 32'd0) begin nerr++; $display("FAIL outset_read got %h expected 0", rd[0]); end
  endtask

  task automatic test_edge_latency();
    @(negedge clk);
    in_p[0][3] = 1'b1;
    address = 3'd0;
    @(negedge clk); #1;
    nvec++;
    if (rd[0][3] !== 1'b0) begin nerr++; $display("FAIL data_after_1 got %b expected 0", rd[0][3]); end
    @(negedge clk); #1;
    nvec++;
    if (rd[0][3] !== 1'b1) begin nerr++; $display("FAIL data_after_2 got %b expected 1", rd[0][3]); end
    address = 3'd3; #1;
    nvec++;
    if (rd[0] !== 32'h00) begin nerr++; $display("FAIL cap_after_2 got %h expected 0", rd[0]); end
    @(negedge clk); #1;
    nvec++;
    if (rd[0] !== 32'h08) begin nerr++; $display("FAIL cap_after_3 got %h expected 08", rd[0]); end
    nvec++;
    if (irq_v[0] !== 1'b0) begin nerr++; $display("FAIL irq_masked got %b expected 0", irq_v[0]); end
    bus_write(3'd2, 32'h08);
    #1;
    nvec++;
    if (irq_v[0] !== 1'b1) begin nerr++; $display("FAIL irq_unmasked got %b expected 1", irq_v[0]); end
  endtask

  task automatic test_clear_race();
    @(negedge clk);
    in_p[0][3] = 1'b0;
    repeat (4) @(negedge clk);
    address = 3'd3; #1;
    nvec++;
    if (rd[0] !== 32'h08) begin nerr++; $display("FAIL cap_hold_on_fall got %h expected 08", rd[0]); end
    in_p[0][3] = 1'b1;
    repeat (2) @(negedge clk);
    address = 3'd3; writedata = 32'h08; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    #1;
    nvec++;
    if (rd[0] !== 32'h08) begin nerr++; $display("FAIL race_cap got %h expected 08", rd[0]); end
    nvec++;
    if (irq_v[0] !== 1'b1) begin nerr++; $display("FAIL race_irq got %b expected 1", irq_v[0]); end
    bus_write(3'd3, 32'h08);
    address = 3'd3; #1;
    nvec++;
    if (rd[0] !== 32'h00) begin nerr++; $display("FAIL w1c_cap got %h expected 0", rd[0]); end
    nvec++;
    if (irq_v[0] !== 1'b0) begin nerr++; $display("FAIL w1c_irq got %b expected 0", irq_v[0]); end
  endtask

  task automatic test_falling_any();
    logic [7:0] exp_cap [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) in_p[k] = 8'h00;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    in_p[1][0] = 1'b1; in_p[2][0] = 1'b1;
    repeat (4) @(negedge clk);
    address = 3'd3; #1;
    nvec++;
    if (rd[1] !== 32'h00) begin nerr++; $display("FAIL fall_on_rise got %h expected 0", rd[1]); end
    nvec++;
    if (rd[2] !== 32'h01) begin nerr++; $display("FAIL any_on_rise got %h expected 01", rd[2]); end
    bus_write(3'd3, 32'h01);
    address = 3'd3; #1;
    nvec++;
    if (rd[2] !== 32'h00) begin nerr++; $display("FAIL any_cleared got %h expected 0", rd[2]); end
    in_p[1][0] = 1'b0; in_p[2][0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    nvec++;
    if (rd[1] !== 32'h01) begin nerr++; $display("FAIL fall_on_fall got %h expected 01", rd[1]); end
    nvec++;
    if (rd[2] !== 32'h01) begin nerr++; $display("FAIL any_on_fall got %h expected 01", rd[2]); end
    bus_write(3'd1, 32'h3C);
    bus_write(3'd2, 32'hC3);
    bus_write(3'd0, 32'h5A);
    bus_write(3'd6, 32'hFF);
    bus_write(3'd7, 32'hFF);
    exp_cap[0] = 8'h00; exp_cap[1] = 8'h01; exp_cap[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (op[k] !== 8'h5A) begin nerr++; $display("FAIL hole_out_port k=%0d got %h expected 5a", k, op[k]); end
      nvec++;
      if (oe[k] !== 8'h3C) begin nerr++; $display("FAIL hole_out_en k=%0d got %h expected 3c", k, oe[k]); end
    end
    address = 3'd2; #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (rd[k] !== 32'hC3) begin nerr++; $display("FAIL hole_mask k=%0d got %h expected c3", k, rd[k]); end
    end
    address = 3'd3; #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (rd[k] !== {24'd0, exp_cap[k]}) begin nerr++; $display("FAIL hole_cap k=%0d got %h expected %h", k, rd[k], exp_cap[k]); end
    end
    for (int a = 6; a <= 7; a++) begin
      address = 3'(a); #1;
      nvec++;
      if (rd[0] !== 32'd0) begin nerr++; $display("FAIL hole_read a=%0d got %h expected 0", a, rd[0]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset_n    = !(i >= 150 && i < 152);
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      for (int k = 0; k < 3; k++) in_p[k] = 8'($urandom);
      #1;
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (rd[k] !== mread(k, address)) begin
          nerr++; $display("FAIL rand_read i=%0d k=%0d a=%0d got %h expected %h", i, k, address, rd[k], mread(k, address));
        end
        nvec++;
        if (op[k] !== m_dout[k]) begin nerr++; $display("FAIL rand_out_port i=%0d k=%0d got %h expected %h", i, k, op[k], m_dout[k]); end
        nvec++;
        if (oe[k] !== m_dir[k]) begin nerr++; $display("FAIL rand_out_en i=%0d k=%0d got %h expected %h", i, k, oe[k], m_dir[k]); end
        nvec++;
        if (irq_v[k] !== |(m_cap[k] & m_mask[k])) begin
          nerr++; $display("FAIL rand_irq i=%0d k=%0d got %b expected %b", i, k, irq_v[k], |(m_cap[k] & m_mask[k]));
        end
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    for (int k = 0; k < 3; k++) in_p[k] = 8'h00;
    test_reset();
    test_set_clear();
    test_edge_latency();
    test_clear_race();
    test_falling_any();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
